// File: rtl/icap_cmd_seq.sv
// icap_cmd_seq: single-owner sequencer for the Spartan-6 ICAP primitive.
//
// Arbitrates a warm-reboot requester (IPROG to a runtime SPI address) and a
// status-readback requester (reads STAT), emitting one 16-bit ICAP word per
// clock. The ICAP instance lives outside this block; all ICAP-facing outputs
// are registered.
//
// Optional feature macro: ICAP_STATUS_READ_EN
//   defined   - STAT readback path present.
//   undefined - reboot-only sequencer; rd_req ignored, rd_* outputs tied to 0.
//
// Ports:
//   clk, rst_n          clock (also drives ICAP CLK) and async active-low reset
//   reboot_req          pulse; sets a sticky reboot-pending flag
//   boot_addr[23:0]     SPI boot address, latched at reboot grant
//   rd_req              pulse; STAT readback, accepted only when idle
//   busy                high from grant until return to idle
//   rd_done, rd_err     end-of-readback pulse and its timeout flag
//   rd_data[15:0]       last captured STAT value (logical bit order)
//   icap_ce_n           ICAP CE, active low
//   icap_write_n        ICAP WRITE (0 = write, 1 = read)
//   icap_i[15:0]        ICAP data in (bit-swapped per BITSWAP)
//   icap_o[15:0]        ICAP data out
//   icap_busy           ICAP BUSY
module icap_cmd_seq #(
  parameter logic [23:0] FALLBACK_ADDR = 24'h000000,
  parameter logic [7:0]  SPI_OPCODE    = 8'h0B,
  parameter bit          BITSWAP       = 1'b1,
  parameter int unsigned RD_TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reboot_req,
  input  logic [23:0] boot_addr,
  input  logic        rd_req,
  output logic        busy,
  output logic        rd_done,
  output logic        rd_err,
  output logic [15:0] rd_data,
  output logic        icap_ce_n,
  output logic        icap_write_n,
  output logic [15:0] icap_i,
  input  logic [15:0] icap_o,
  input  logic        icap_busy
);

  typedef enum logic [2:0] {
    StIdle, StWrBoot, StWrRdcmd, StSwToRd, StRdWait, StSwToWr, StWrDesync
  } state_e;

  // Reverses bit order within each byte; the ICAP port expects this ordering.
  function automatic logic [15:0] swap_bits(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7-i];
      r[8 + i] = w[15-i];
    end
    return BITSWAP ? r : w;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  // Set once the final word of a write burst has been issued, so the 4-bit
  // counter never has to wrap to mark the end of a sequence.
  logic        last_q, last_d;
  logic        pend_q, pend_d;
  logic [23:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        ce_n_q, ce_n_d;
  logic        write_n_q, write_n_d;
  logic [15:0] icap_i_q, icap_i_d;

  logic        wr_state;
  logic [3:0]  wr_last;
  logic [15:0] wr_word;
  logic        wr_hold;

`ifdef ICAP_STATUS_READ_EN
  localparam int unsigned TmoW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            rd_done_q, rd_done_d;
  logic            rd_err_q, rd_err_d;
  logic [15:0]     rd_data_q, rd_data_d;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_req, icap_o};
`endif

  // A driven write word that ICAP reports busy on is held, with no timeout.
  assign wr_hold = !ce_n_q && !write_n_q && icap_busy;

  // Word ROM for the write bursts (pre-swap values).
  always_comb begin
    wr_state = 1'b0;
    wr_last  = 4'd15;
    wr_word  = 16'hFFFF;
    case (state_q)
      StWrBoot: begin
        wr_state = 1'b1;
        wr_last  = 4'd15;
        case (cnt_q)
          4'd0, 4'd1: wr_word = 16'hFFFF;
          4'd2:       wr_word = 16'hAA99;
          4'd3:       wr_word = 16'h5566;
          4'd4:       wr_word = 16'h3261;
          4'd5:       wr_word = addr_q[15:0];
          4'd6:       wr_word = 16'h3281;
          4'd7:       wr_word = {SPI_OPCODE, addr_q[23:16]};
          4'd8:       wr_word = 16'h32A1;
          4'd9:       wr_word = FALLBACK_ADDR[15:0];
          4'd10:      wr_word = 16'h32C1;
          4'd11:      wr_word = {SPI_OPCODE, FALLBACK_ADDR[23:16]};
          4'd12:      wr_word = 16'h30A1;
          4'd13:      wr_word = 16'h000E;
          default:    wr_word = 16'h2000;
        endcase
      end
`ifdef ICAP_STATUS_READ_EN
      StWrRdcmd: begin
        wr_state = 1'b1;
        wr_last  = 4'd6;
        case (cnt_q)
          4'd0:    wr_word = 16'hFFFF;
          4'd1:    wr_word = 16'hAA99;
          4'd2:    wr_word = 16'h5566;
          4'd4:    wr_word = 16'h2901;  // type-1 read STAT, 1 word
          default: wr_word = 16'h2000;
        endcase
      end
      StWrDesync: begin
        wr_state = 1'b1;
        wr_last  = 4'd3;
        case (cnt_q)
          4'd0:    wr_word = 16'h30A1;
          4'd1:    wr_word = 16'h000D;
          default: wr_word = 16'h2000;
        endcase
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    pend_d    = pend_q | reboot_req;
    addr_d    = addr_q;
    busy_d    = busy_q;
    ce_n_d    = ce_n_q;
    write_n_d = write_n_q;
    icap_i_d  = icap_i_q;
`ifdef ICAP_STATUS_READ_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
    rd_done_d = 1'b0;
    rd_err_d  = 1'b0;
    rd_data_d = rd_data_q;
`endif

    // Issue the next word of whichever write burst is active.
    if (wr_state && !wr_hold && !last_q) begin
      ce_n_d   = 1'b0;
      icap_i_d = swap_bits(wr_word);
      if (cnt_q == wr_last) begin
        last_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    case (state_q)
      StIdle: begin
        // Reboot has priority; a simultaneous rd_req is dropped.
        if (pend_q || reboot_req) begin
          state_d = StWrBoot;
          addr_d  = boot_addr;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
          last_d  = 1'b0;
        end
`ifdef ICAP_STATUS_READ_EN
        else if (rd_req) begin
          state_d = StWrRdcmd;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
          last_d  = 1'b0;
          err_d   = 1'b0;
        end
`endif
      end
      StWrBoot: begin
        if (last_q && !wr_hold) begin
          state_d = StIdle;
          ce_n_d  = 1'b1;
          last_d  = 1'b0;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          pend_d  = reboot_req;
        end
      end
`ifdef ICAP_STATUS_READ_EN
      StWrRdcmd: begin
        if (last_q && !wr_hold) begin
          // CE rises first; WRITE flips on the following cycle.
          state_d = StSwToRd;
          ce_n_d  = 1'b1;
          last_d  = 1'b0;
          cnt_d   = 4'd0;
        end
      end
      StSwToRd: begin
        write_n_d = 1'b1;
        state_d   = StRdWait;
      end
      StRdWait: begin
        if (ce_n_q) begin
          ce_n_d = 1'b0;
          tmo_d  = '0;
        end else if (!icap_busy) begin
          rd_data_d = swap_bits(icap_o);
          ce_n_d    = 1'b1;
          state_d   = StSwToWr;
        end else if (tmo_q == TmoW'(RD_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          ce_n_d  = 1'b1;
          state_d = StSwToWr;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StSwToWr: begin
        write_n_d = 1'b0;
        state_d   = StWrDesync;
      end
      StWrDesync: begin
        if (last_q && !wr_hold) begin
          state_d   = StIdle;
          ce_n_d    = 1'b1;
          last_d    = 1'b0;
          cnt_d     = 4'd0;
          busy_d    = 1'b0;
          rd_done_d = 1'b1;
          rd_err_d  = err_q;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      last_q    <= 1'b0;
      pend_q    <= 1'b0;
      addr_q    <= 24'h0;
      busy_q    <= 1'b0;
      ce_n_q    <= 1'b1;
      write_n_q <= 1'b0;
      icap_i_q  <= 16'hFFFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      ce_n_q    <= ce_n_d;
      write_n_q <= write_n_d;
      icap_i_q  <= icap_i_d;
    end
  end

`ifdef ICAP_STATUS_READ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q     <= '0;
      err_q     <= 1'b0;
      rd_done_q <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= 16'h0;
    end else begin
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      rd_done_q <= rd_done_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_done = rd_done_q;
  assign rd_err  = rd_err_q;
  assign rd_data = rd_data_q;
`else
  assign rd_done = 1'b0;
  assign rd_err  = 1'b0;
  assign rd_data = 16'h0;
`endif

  assign busy         = busy_q;
  assign icap_ce_n    = ce_n_q;
  assign icap_write_n = write_n_q;
  assign icap_i       = icap_i_q;

endmodule

// File: doc/icap_cmd_seq.md
Name: icap_cmd_seq

Overview:
- Single-owner sequencer for the Spartan-6 ICAP primitive.
- Arbitrates two requesters and emits the 16-bit ICAP word streams, one word per clock:
  - Warm-reboot requester: IPROG to a runtime-supplied SPI boot address.
  - Status-readback requester: reads the STAT register.
- Sits between the loader control logic and the ICAP instance.
- The ICAP instance itself lives outside this block.

Parameters:
- FALLBACK_ADDR, 24'h000000: fallback (golden) image SPI address, written to General 3/4.
- SPI_OPCODE, 8'h0B: SPI read opcode placed in General 2 [15:8] and General 4 [15:8].
- BITSWAP, 1: 1 = reverse bit order within each byte on icap_i and icap_o, as the ICAP port requires; 0 = pass straight.
- RD_TIMEOUT, 255: maximum cycles spent waiting for icap_busy low during readback.

Ports:
- clk  in  1  sole clock; ICAP CLK is driven from the same net.
- rst_n  in  1  asynchronous, active-low reset.
- reboot_req  in  1  one-cycle pulse; request IPROG.
- boot_addr  in  24  SPI boot address, sampled when a reboot is granted.
- rd_req  in  1  one-cycle pulse; request STAT readback.
- busy  out  1  high from the grant cycle until the sequence returns to IDLE.
- rd_done  out  1  one-cycle pulse when readback ends.
- rd_err  out  1  valid with rd_done; 1 = timeout.
- rd_data  out  16  captured STAT value, unswapped; held until the next readback.
- icap_ce_n  out  1  ICAP CE, active low.
- icap_write_n  out  1  ICAP WRITE; 0 = write, 1 = read.
- icap_i  out  16  ICAP data in, swapped per BITSWAP.
- icap_o  in  16  ICAP data out.
- icap_busy  in  1  ICAP BUSY.

Behaviour:
- Reset values: busy=0, rd_done=0, rd_err=0, rd_data=0, icap_ce_n=1, icap_write_n=0, icap_i=16'hFFFF (pre-swap).
- All ICAP outputs are registered.
- States: IDLE, WR_BOOT, WR_RDCMD, SW_TO_RD, RD_WAIT, SW_TO_WR, WR_DESYNC.
- Request latching:
  - A reboot_req pulse sets a sticky pending flag, including while busy.
  - rd_req is accepted only in IDLE; if busy, it is dropped.
  - IDLE with reboot pending and rd_req in the same cycle: the reboot wins and rd_req is dropped.
- Grant at edge N: boot_addr latched, busy=1, word 0 driven with icap_ce_n=0 from edge N+1; word k appears at edge N+1+k.
- WR_BOOT words, pre-swap, in order (16 words):
  - FFFF, FFFF, AA99, 5566
  - 3261, boot_addr[15:0]
  - 3281, {SPI_OPCODE, boot_addr[23:16]}
  - 32A1, FALLBACK_ADDR[15:0]
  - 32C1, {SPI_OPCODE, FALLBACK_ADDR[23:16]}
  - 30A1, 000E, 2000, 2000
- After WR_BOOT: icap_ce_n=1, pending flag cleared, return to IDLE.
  - Real silicon reboots at this point; in simulation the block must be able to accept new requests.
- WR_RDCMD words, in order: FFFF, AA99, 5566, 2000, 2901 (type-1 read STAT, 1 word), 2000, 2000.
- SW_TO_RD:
  - Cycle 1: icap_ce_n=1 with icap_write_n=0.
  - Cycle 2: icap_ce_n=1 with icap_write_n=1.
  - CE and WRITE never change in the same cycle.
- RD_WAIT:
  - icap_ce_n=0, icap_write_n=1.
  - On the first cycle icap_busy is sampled 0, capture icap_o (unswapped) into rd_data.
  - If RD_TIMEOUT cycles elapse with icap_busy=1: set rd_err and leave rd_data unchanged.
- SW_TO_WR: mirror of SW_TO_RD (CE high first, then WRITE low).
- WR_DESYNC words, in order: 30A1, 000D, 2000, 2000.
- End of readback: rd_done pulses with rd_err on the cycle after the last desync word; busy drops the same cycle.
- Write-word flow control:
  - If icap_busy=1 during a write word, hold the word and the counter.
  - Outside RD_WAIT the hold has no timeout.
- Mid-sequence reset: all outputs return to reset values immediately and the pending flag clears. No partial re-issue.
- The word counter is 4 bits; it must not wrap into a new sequence.

Optional Feature:
- ICAP_STATUS_READ_EN.
- Defined: the readback path exists as described.
- Undefined:
  - States WR_RDCMD through WR_DESYNC are removed.
  - rd_req is ignored.
  - rd_done, rd_err and rd_data are tied to 0.
  - The block degenerates to the reboot-only sequencer.

Test Plan:
- Reboot: rst_n release; reboot_req with boot_addr=24'h010000 -> 16 words FFFF, FFFF, AA99, 5566, 3261, 0000, 3281, 0B01, 32A1, 0000, 32C1, 0B00, 30A1, 000E, 2000, 2000 (pre-swap, BITSWAP=0) on consecutive cycles with ce_n=0; busy high for 17 cycles.
- Readback: rd_req; model icap_busy=1 for 3 read cycles, then icap_o=16'h3CEC -> rd_data=16'h3CEC, rd_err=0, one rd_done pulse, desync words 30A1, 000D observed; CE is never low while WRITE toggles.
- Timeout: rd_req with icap_busy stuck at 1, RD_TIMEOUT=8 -> rd_done with rd_err=1 after 8 wait cycles, rd_data unchanged, desync still issued.
- Arbitration: reboot_req and rd_req in the same cycle -> reboot stream only, no rd_done. reboot_req pulsed mid-readback -> reboot stream starts right after rd_done.
- Async reset: assert rst_n low at word 6 of WR_BOOT -> icap_ce_n=1 and busy=0 without a clock edge; after release there is no further activity until a new request.
- BITSWAP=1: word AA99 appears on icap_i as 5599.
